// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse cipher sequencer.
// Holds the 128-bit state and the round counter, and applies InvShiftRows and
// AddRoundKey itself. One external registered InvSubBytes matrix and one
// external combinational 32-bit InvMixColumns unit are shared across all rounds.
// Byte layout is column-major: s[r][c] = state[127-8*(4c+r) -: 8].
module aes_inv_cipher_ctrl #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [127:0]          msg_enc,
    input  logic [128*(NR+1)-1:0] key_schedule,
    output logic [127:0]          msg_dec,
    output logic                  done,
    output logic                  busy,
    output logic [127:0]          isb_in,
    input  logic [127:0]          isb_out,
    output logic [31:0]           imc_in,
    input  logic [31:0]           imc_out,
    output logic [3:0]            round
);

    localparam int KW = 128 * (NR + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ISR,
        S_ISB_W,
        S_ISB_C,
        S_ARK,
        S_IMC0,
        S_IMC1,
        S_IMC2,
        S_IMC3,
        S_DONE
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic [127:0] r_msg_dec;
    logic [127:0] w_round_key;
    logic [127:0] w_ark;

    // out[r][c] = in[r][(c - r) mod 4]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // State register of the sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= S_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops update from
            // pre-edge values, matching the hardware regardless of statement order.
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state decode plus the done/busy/imc_in outputs.
    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_fsm_next = r_fsm;
        done       = 1'b0;
        busy       = (r_fsm != S_IDLE) && (r_fsm != S_DONE);
        imc_in     = '0;
        case (r_fsm)
            S_IDLE:  if (start) w_fsm_next = S_LOAD;
            S_LOAD:  w_fsm_next = S_ISR;
            S_ISR:   w_fsm_next = S_ISB_W;
            S_ISB_W: w_fsm_next = S_ISB_C;
            S_ISB_C: w_fsm_next = S_ARK;
            S_ARK:   w_fsm_next = (r_round == 4'd0) ? S_DONE : S_IMC0;
            S_IMC0: begin
                imc_in     = r_state[127:96];
                w_fsm_next = S_IMC1;
            end
            S_IMC1: begin
                imc_in     = r_state[95:64];
                w_fsm_next = S_IMC2;
            end
            S_IMC2: begin
                imc_in     = r_state[63:32];
                w_fsm_next = S_IMC3;
            end
            S_IMC3: begin
                imc_in     = r_state[31:0];
                w_fsm_next = S_ISR;
            end
            S_DONE: begin
                done = 1'b1;
                // A held start keeps us here; only its release re-arms IDLE.
                if (!start) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // Round-key select: key k sits at the MSB end for k = 0.
    always_comb begin
        w_round_key = '0;
        for (int k = 0; k <= NR; k++) begin
            if (r_round == 4'(k)) w_round_key = key_schedule[KW-1-128*k -: 128];
        end
    end

    assign w_ark = r_state ^ w_round_key;

    // Datapath: state, round counter and the plaintext result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= '0;
            r_round   <= '0;
            r_msg_dec <= '0;
        end else begin
            case (r_fsm)
                S_LOAD: begin
                    r_state <= msg_enc ^ key_schedule[127:0];
                    r_round <= 4'(NR - 1);
                end
                S_ISR:   r_state <= inv_shift_rows(r_state);
                S_ISB_C: r_state <= isb_out;
                S_ARK: begin
                    r_state <= w_ark;
                    // Only the final AddRoundKey publishes a result.
                    if (r_round == 4'd0) r_msg_dec <= w_ark;
                end
                S_IMC0: r_state[127:96] <= imc_out;
                S_IMC1: r_state[95:64]  <= imc_out;
                S_IMC2: r_state[63:32]  <= imc_out;
                S_IMC3: begin
                    r_state[31:0] <= imc_out;
                    // Reached only after ARK with round >= 1, so no underflow.
                    r_round       <= r_round - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign msg_dec = r_msg_dec;
    assign isb_in  = r_state;
    assign round   = r_round;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl. Supplies behavioural models of the
// registered InvSubBytes matrix and the combinational InvMixColumns word unit,
// expands round keys locally, and compares against FIPS-197 vectors.
module tb_aes_inv_cipher_ctrl;

    localparam int NR = 10;
    localparam int KW = 128 * (NR + 1);
    localparam int LAT = 77;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [127:0]    msg_enc;
    logic [KW-1:0]   key_schedule;
    logic [127:0]    msg_dec;
    logic            done;
    logic            busy;
    logic [127:0]    isb_in;
    logic [127:0]    isb_out;
    logic [31:0]     imc_in;
    logic [31:0]     imc_out;
    logic [3:0]      round;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    sbox     [256];
    logic [7:0]    inv_sbox [256];
    logic [KW-1:0] ks_c1;
    logic [KW-1:0] ks_zero;
    logic [127:0]  prev_plain;

    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_LOAD  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_ISB1  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] C1_R2    = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_inv_cipher_ctrl #(.NR(NR)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .msg_enc      (msg_enc),
        .key_schedule (key_schedule),
        .msg_dec      (msg_dec),
        .done         (done),
        .busy         (busy),
        .isb_in       (isb_in),
        .isb_out      (isb_out),
        .imc_in       (imc_in),
        .imc_out      (imc_out),
        .round        (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // External InvSubBytes matrix: registered, one edge of latency.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) isb_out[8*i +: 8] <= inv_sbox[isb_in[8*i +: 8]];
    end

    // External InvMixColumns word unit: combinational.
    always_comb imc_out = inv_mix_col(imc_in);

    // S-box from the GF(2^8) inverse followed by the affine transform.
    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [KW-1:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = {t[23:0], t[31:24]};
                t    = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int i = 0; i < 44; i++) ks[KW-1-32*i -: 32] = w[i];
        return ks;
    endfunction

    // Runs one operation, holding start for 'hold' sampled edges, and checks
    // the cycle-by-cycle protocol, the latency and the final plaintext.
    task automatic run_op(input string tag, input logic [127:0] ct, input logic [KW-1:0] ks,
                          input logic [127:0] exp_pt, input int hold, input bit check_mid);
        int         last;
        int         isb_uses;
        bit         exp_done;
        bit         exp_busy;
        bit         in_imc;
        logic [3:0] exp_round;
        logic [127:0] exp_dec;
        last     = ((hold > LAT) ? hold : LAT) + 1;
        isb_uses = 0;
        @(negedge clk);
        msg_enc      = ct;
        key_schedule = ks;
        start        = 1'b1;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk);
            #1;
            exp_done = (n == LAT) || (n > LAT && n < hold);
            exp_busy = (n < LAT);
            n_checks++;
            if (done !== exp_done) begin
                n_errors++;
                $display("FAIL %s done n=%0d got %b want %b", tag, n, done, exp_done);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_errors++;
                $display("FAIL %s busy n=%0d got %b want %b", tag, n, busy, exp_busy);
            end
            in_imc = (n >= 1) && (n <= 72) && (((n - 1) % 8) >= 4);
            if (!in_imc) begin
                n_checks++;
                if (imc_in !== 32'h0) begin
                    n_errors++;
                    $display("FAIL %s imc_in_idle n=%0d got %h want 0", tag, n, imc_in);
                end
            end
            if (n >= 1) begin
                exp_round = (n >= 73) ? 4'd0 : 4'(9 - (n - 1) / 8);
                n_checks++;
                if (round !== exp_round) begin
                    n_errors++;
                    $display("FAIL %s round n=%0d got %0d want %0d", tag, n, round, exp_round);
                end
            end
            exp_dec = (n >= LAT) ? exp_pt : prev_plain;
            n_checks++;
            if (msg_dec !== exp_dec) begin
                n_errors++;
                $display("FAIL %s msg_dec n=%0d got %h want %h", tag, n, msg_dec, exp_dec);
            end
            if (n >= 1 && n < LAT && isb_in === isb_out) isb_uses++;
            if (check_mid && (n == 1 || n == 4 || n == 9)) begin
                n_checks++;
                if (n == 1 && isb_in !== C1_LOAD) begin
                    n_errors++;
                    $display("FAIL %s state_after_load got %h want %h", tag, isb_in, C1_LOAD);
                end
                if (n == 4 && isb_in !== C1_ISB1) begin
                    n_errors++;
                    $display("FAIL %s state_after_isb_c got %h want %h", tag, isb_in, C1_ISB1);
                end
                if (n == 9 && isb_in !== C1_R2) begin
                    n_errors++;
                    $display("FAIL %s state_after_imc3 got %h want %h", tag, isb_in, C1_R2);
                end
            end
            if (n == hold - 1) start = 1'b0;
        end
        n_checks++;
        if (isb_uses != 10) begin
            n_errors++;
            $display("FAIL %s isb_uses got %0d want 10", tag, isb_uses);
        end
        prev_plain = exp_pt;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({msg_dec, done, busy, imc_in, isb_in, round} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got msg_dec=%h done=%b busy=%b imc_in=%h isb_in=%h round=%0d want all 0",
                     msg_dec, done, busy, imc_in, isb_in, round);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, busy, round} !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset got done=%b busy=%b round=%0d want 0 0 0", done, busy, round);
        end
    endtask

    task automatic test_c1_decrypt();
        run_op("c1", C1_CT, ks_c1, C1_PT, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_zero", ZERO_CT, ks_zero, 128'h0, 1, 1'b0);
    endtask

    task automatic test_handshake();
        run_op("hold200", C1_CT, ks_c1, C1_PT, 200, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        msg_enc      = C1_CT;
        key_schedule = ks_c1;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_run_busy got %b want 1", busy);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({msg_dec, done, busy, imc_in, isb_in, round} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got msg_dec=%h done=%b busy=%b imc_in=%h isb_in=%h round=%0d want all 0",
                     msg_dec, done, busy, imc_in, isb_in, round);
        end
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        prev_plain = 128'h0;
        run_op("after_reset", C1_CT, ks_c1, C1_PT, 1, 1'b1);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        msg_enc      = '0;
        key_schedule = '0;
        prev_plain   = '0;
        build_sbox();
        ks_c1   = expand_key(128'h000102030405060708090a0b0c0d0e0f);
        ks_zero = expand_key(128'h0);
        test_reset();
        test_c1_decrypt();
        test_back_to_back();
        test_handshake();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
